arb_mux: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshaking on every input and on the output. It replaces bare combinational select-line muxing wherever several producers share one datapath. It provides two modes: fixed selection, where a select port chooses the channel, and round-robin arbitration among requesting channels. The output is held in a one-entry register, so downstream back-pressure is absorbed without dropping or duplicating data.

---
 rtl/arb_mux_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 59 +++++
 rtl/arb_mux.sv | 151 +++++++++++++++
 tb/tb_arb_mux.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_mux_pkg.sv
// ----------------------------------------------------------------------------
// arb_mux_pkg
// Shared constants and helpers for the arb_mux registered multiplexer.
//   MODE_FIXED : mode value selecting the channel given by the sel port
//   MODE_RR    : mode value selecting round-robin arbitration
//   wrap_next  : index + 1, wrapping to 0 at n (works for any n, not only 2^k)
// ----------------------------------------------------------------------------
package arb_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Successor of idx in the ring 0..n-1.
    function automatic int unsigned wrap_next(input int unsigned idx, input int unsigned n);
        if ((idx + 32'd1) >= n) begin
            return 32'd0;
        end else begin
            return idx + 32'd1;
        end
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational rotating-priority picker. Starting at ptr and moving
// upward (wrapping at CHANNELS), the first requesting channel wins.
// Ports:
//   req    [CHANNELS] : request vector, bit i belongs to channel i
//   ptr    [SELW]     : highest-priority channel index this cycle (< CHANNELS)
//   winner [SELW]     : index of the chosen channel (0 when nothing requests)
//   any               : at least one request is present
// ----------------------------------------------------------------------------
module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter int CHANNELS = 4,
    localparam int SELW = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SELW-1:0]     ptr,
    output logic [SELW-1:0]     winner,
    output logic                any
);

    // One extra bit so ptr + offset cannot overflow before the wrap.
    localparam int SUMW = SELW + 1;

    logic [SUMW-1:0] sum_s;
    logic [SELW-1:0] pos_s;
    logic [SELW-1:0] winner_s;
    logic            any_s;

    // Scan channels in priority order ptr, ptr+1, ... and latch the first hit.
    always_comb begin
        winner_s = '0;
        any_s    = 1'b0;
        sum_s    = '0;
        pos_s    = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            sum_s = {1'b0, ptr} + SUMW'(k);
            // ptr + k never reaches 2*CHANNELS, so a single subtraction wraps it.
            if (sum_s >= SUMW'(CHANNELS)) begin
                sum_s = sum_s - SUMW'(CHANNELS);
            end else begin
                sum_s = sum_s;
            end
            pos_s = sum_s[SELW-1:0];
            if (!any_s && req[pos_s]) begin
                any_s    = 1'b1;
                winner_s = pos_s;
            end else begin
                any_s    = any_s;
                winner_s = winner_s;
            end
        end
    end

    assign winner = winner_s;
    assign any    = any_s;

endmodule

// File: rtl/arb_mux.sv
// ----------------------------------------------------------------------------
// arb_mux
// N-channel, W-bit multiplexer with valid/ready on every input and a
// one-entry output register. Channel choice is either the sel port (fixed
// mode) or round-robin among requesting channels.
// Ports:
//   clk, rst              : rising-edge clock, synchronous active-high reset
//   mode                  : MODE_FIXED (use sel) or MODE_RR (round-robin)
//   sel       [SELW]      : channel index used in fixed mode
//   in_valid  [CHANNELS]  : per-channel request
//   in_data   [CHANNELS*WIDTH] : channel i at [i*WIDTH +: WIDTH]
//   in_ready  [CHANNELS]  : per-channel accept (combinational, one-hot or 0)
//   out_valid             : output register holds a word
//   out_data  [WIDTH]     : registered selected word
//   out_ready             : downstream accept
//   grant     [SELW]      : channel whose word sits in the output register
// ----------------------------------------------------------------------------
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    localparam int SELW    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic [SELW-1:0]           sel,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    input  logic                      out_ready,
    output logic [SELW-1:0]           grant
);

    // Every value sel can take has a slot; slots past CHANNELS stay 0 so an
    // out-of-range sel simply sees no request.
    localparam int SELP = 1 << SELW;

    logic [SELP-1:0]     valid_pad_s;
    logic [SELW-1:0]     rr_winner_s;
    logic                rr_any_s;
    logic [SELW-1:0]     winner_s;
    logic                request_s;
    logic                load_en_s;
    logic                transfer_s;
    logic [WIDTH-1:0]    win_data_s;
    logic [CHANNELS-1:0] in_ready_s;
    logic [SELW-1:0]     ptr_next_s;

    logic [SELW-1:0]     ptr_r;
    logic                out_valid_r;
    logic [WIDTH-1:0]    out_data_r;
    logic [SELW-1:0]     grant_r;

    rr_arbiter #(
        .CHANNELS (CHANNELS)
    ) u_rr_arbiter (
        .req    (in_valid),
        .ptr    (ptr_r),
        .winner (rr_winner_s),
        .any    (rr_any_s)
    );

    // Zero-extend the request vector to the full sel range.
    always_comb begin
        valid_pad_s                 = '0;
        valid_pad_s[CHANNELS-1:0]   = in_valid;
    end

    // Pick the candidate channel for this cycle according to the mode.
    always_comb begin
        if (mode == MODE_RR) begin
            winner_s  = rr_winner_s;
            request_s = rr_any_s;
        end else begin
            winner_s  = sel;
            request_s = valid_pad_s[sel];
        end
    end

    // The output register can take a word when empty or being drained now.
    assign load_en_s  = !out_valid_r || out_ready;
    assign transfer_s = load_en_s && request_s;

    // Ready goes only to the winning channel, and only if a load can happen.
    always_comb begin
        in_ready_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (transfer_s && (winner_s == SELW'(i))) begin
                in_ready_s[i] = 1'b1;
            end else begin
                in_ready_s[i] = 1'b0;
            end
        end
    end

    // Data mux for the winning channel.
    always_comb begin
        win_data_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (winner_s == SELW'(i)) begin
                win_data_s = in_data[i*WIDTH +: WIDTH];
            end else begin
                win_data_s = win_data_s;
            end
        end
    end

    assign ptr_next_s = SELW'(wrap_next(32'(rr_winner_s), 32'(CHANNELS)));

    // Round-robin pointer: advances past the winner on each RR transfer only.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (transfer_s && (mode == MODE_RR)) begin
            ptr_r <= ptr_next_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Output register: refill on transfer, empty on drain, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            grant_r     <= '0;
        end else if (transfer_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= win_data_s;
            grant_r     <= winner_s;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
            out_data_r  <= out_data_r;
            grant_r     <= grant_r;
        end else begin
            out_valid_r <= out_valid_r;
            out_data_r  <= out_data_r;
            grant_r     <= grant_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign grant     = grant_r;

endmodule

// File: tb/tb_arb_mux.sv
// ----------------------------------------------------------------------------
// tb_arb_mux
// Two arb_mux instances: A (CHANNELS=4, WIDTH=8) and B (CHANNELS=3, WIDTH=16).
// A queue-free behavioural model (register contents + RR pointer as plain
// integers) predicts outputs every cycle; directed phases add literal checks.
// ----------------------------------------------------------------------------
module tb_arb_mux;
    import arb_mux_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A pins
    logic        a_rst, a_mode, a_out_ready, a_out_valid;
    logic [1:0]  a_sel, a_grant;
    logic [3:0]  a_in_valid, a_in_ready;
    logic [31:0] a_in_data;
    logic [7:0]  a_out_data;

    // Instance B pins
    logic        b_rst, b_mode, b_out_ready, b_out_valid;
    logic [1:0]  b_sel, b_grant;
    logic [2:0]  b_in_valid, b_in_ready;
    logic [47:0] b_in_data;
    logic [15:0] b_out_data;

    arb_mux #(.WIDTH(8), .CHANNELS(4)) u_a (
        .clk(clk), .rst(a_rst), .mode(a_mode), .sel(a_sel),
        .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
        .grant(a_grant)
    );

    arb_mux #(.WIDTH(16), .CHANNELS(3)) u_b (
        .clk(clk), .rst(b_rst), .mode(b_mode), .sel(b_sel),
        .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
        .grant(b_grant)
    );

    // Stimulus state per instance (index 0 = A, 1 = B)
    int          nch [2];
    logic        cur_rst [2];
    logic        cur_mode [2];
    logic        cur_ordy [2];
    logic [1:0]  cur_sel [2];
    logic [3:0]  cur_valid [2];
    logic [15:0] cur_data [2][4];
    bit          rand_en [2];
    bit          primed [2];
    int          xfer_ch [2];
    logic [3:0]  last_rdy [2];

    // Model state
    logic        m_valid [2];
    logic [15:0] m_data [2];
    int          m_grant [2];
    int          m_ptr [2];

    int n_pass;
    int n_total;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Which channel should be picked, by the mode rules.
    function automatic void model_pick(input int d, output bit req, output int w);
        req = 1'b0;
        w   = 0;
        if (cur_mode[d] == MODE_FIXED) begin
            w   = int'(cur_sel[d]);
            req = (w < nch[d]) && cur_valid[d][w];
        end else begin
            for (int k = 0; k < nch[d]; k++) begin
                int idx = (m_ptr[d] + k) % nch[d];
                if (!req && cur_valid[d][idx]) begin
                    req = 1'b1;
                    w   = idx;
                end
            end
        end
    endfunction

    function automatic logic [3:0] exp_rdy(input int d);
        bit req;
        int w;
        model_pick(d, req, w);
        if ((!m_valid[d] || cur_ordy[d]) && req) return 4'(1 << w);
        return 4'b0000;
    endfunction

    task automatic model_update(input int d);
        bit req;
        int w;
        model_pick(d, req, w);
        xfer_ch[d] = -1;
        if (cur_rst[d]) begin
            m_valid[d] = 1'b0;
            m_data[d]  = 16'h0000;
            m_grant[d] = 0;
            m_ptr[d]   = 0;
            primed[d]  = 1'b1;
        end else if ((!m_valid[d] || cur_ordy[d]) && req) begin
            m_valid[d] = 1'b1;
            m_data[d]  = cur_data[d][w];
            m_grant[d] = w;
            if (cur_mode[d] == MODE_RR) m_ptr[d] = (w + 1) % nch[d];
            xfer_ch[d] = w;
        end else if (m_valid[d] && cur_ordy[d]) begin
            m_valid[d] = 1'b0;
        end
    endtask

    task automatic check_dut(input int d);
        logic        av;
        logic [15:0] ad;
        logic [1:0]  ag;
        logic [3:0]  ar;
        string       p;
        if (d == 0) begin
            av = a_out_valid; ad = {8'h00, a_out_data}; ag = a_grant; ar = a_in_ready; p = "a_";
        end else begin
            av = b_out_valid; ad = b_out_data; ag = b_grant; ar = {1'b0, b_in_ready}; p = "b_";
        end
        last_rdy[d] = ar;
        if (primed[d]) begin
            chk({p, "out_valid"}, 32'(av), 32'(m_valid[d]));
            chk({p, "out_data"},  32'(ad), 32'(m_data[d]));
            chk({p, "grant"},     32'(ag), 32'(m_grant[d]));
            chk({p, "in_ready"},  32'(ar), 32'(exp_rdy(d)));
        end
    endtask

    task automatic randomize_inputs(input int d);
        cur_rst[d]  = ($urandom_range(0, 99) == 0);
        if ($urandom_range(0, 15) == 0) cur_mode[d] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0)  cur_sel[d]  = 2'($urandom_range(0, 3));
        cur_ordy[d] = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < nch[d]; i++) begin
            // Producers hold a pending word until it is taken.
            if (!(cur_valid[d][i] && xfer_ch[d] != i)) begin
                cur_valid[d][i] = 1'($urandom_range(0, 1));
                cur_data[d][i]  = 16'($urandom) & ((d == 0) ? 16'h00FF : 16'hFFFF);
            end
        end
    endtask

    task automatic drive_pins();
        a_rst = cur_rst[0]; a_mode = cur_mode[0]; a_sel = cur_sel[0];
        a_in_valid = cur_valid[0]; a_out_ready = cur_ordy[0];
        for (int i = 0; i < 4; i++) a_in_data[i*8 +: 8] = cur_data[0][i][7:0];
        b_rst = cur_rst[1]; b_mode = cur_mode[1]; b_sel = cur_sel[1];
        b_in_valid = cur_valid[1][2:0]; b_out_ready = cur_ordy[1];
        for (int i = 0; i < 3; i++) b_in_data[i*16 +: 16] = cur_data[1][i];
    endtask

    // One clock cycle: drive at the falling edge, compare, advance model.
    task automatic step();
        for (int d = 0; d < 2; d++) if (rand_en[d]) randomize_inputs(d);
        drive_pins();
        #1;
        for (int d = 0; d < 2; d++) check_dut(d);
        for (int d = 0; d < 2; d++) model_update(d);
        @(posedge clk);
        @(negedge clk);
    endtask

    int seq_all [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int seq_odd [4] = '{1, 3, 1, 3};
    int seq_b   [4] = '{0, 1, 2, 0};

    initial begin
        n_pass = 0;
        n_total = 0;
        nch[0] = 4;
        nch[1] = 3;
        for (int d = 0; d < 2; d++) begin
            cur_rst[d] = 1'b1; cur_mode[d] = MODE_FIXED; cur_ordy[d] = 1'b1;
            cur_sel[d] = 2'd0; cur_valid[d] = 4'b0000;
            for (int i = 0; i < 4; i++) cur_data[d][i] = 16'h0000;
            rand_en[d] = 1'b0; primed[d] = 1'b0; xfer_ch[d] = -1;
            m_valid[d] = 1'b0; m_data[d] = 16'h0000; m_grant[d] = 0; m_ptr[d] = 0;
            last_rdy[d] = 4'b0000;
        end

        step();
        step();
        cur_rst[0] = 1'b0;
        cur_rst[1] = 1'b0;
        rand_en[1] = 1'b1;
        chk("rst_valid", 32'(a_out_valid), 32'd0);
        chk("rst_data",  32'(a_out_data),  32'd0);
        chk("rst_grant", 32'(a_grant),     32'd0);

        // Fixed selection
        cur_mode[0] = MODE_FIXED; cur_sel[0] = 2'd2; cur_valid[0] = 4'b1111; cur_ordy[0] = 1'b1;
        cur_data[0][0] = 16'h0011; cur_data[0][1] = 16'h0022;
        cur_data[0][2] = 16'h0033; cur_data[0][3] = 16'h0044;
        step();
        chk("fix2_rdy",   32'(last_rdy[0]), 32'h4);
        chk("fix2_data",  32'(a_out_data),  32'h33);
        chk("fix2_grant", 32'(a_grant),     32'd2);
        cur_sel[0] = 2'd3;
        step();
        chk("fix3_data",  32'(a_out_data),  32'h44);
        chk("fix3_grant", 32'(a_grant),     32'd3);

        // Round-robin fairness
        cur_mode[0] = MODE_RR;
        for (int i = 0; i < 4; i++) cur_data[0][i] = 16'h00A0 + 16'(i);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("rr_all_grant", 32'(a_grant), 32'(seq_all[k]));
            chk("rr_all_data",  32'(a_out_data), 32'(8'hA0 + 8'(seq_all[k])));
        end
        cur_valid[0] = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rr_odd_grant", 32'(a_grant), 32'(seq_odd[k]));
        end

        // Reset with a word held: pointer must restart at channel 0
        cur_valid[0] = 4'b0001; cur_data[0][0] = 16'h00A5;
        step();
        chk("pre_rst_data", 32'(a_out_data), 32'hA5);
        cur_rst[0] = 1'b1; cur_valid[0] = 4'b0000;
        step();
        chk("mid_rst_valid", 32'(a_out_valid), 32'd0);
        chk("mid_rst_data",  32'(a_out_data),  32'd0);
        chk("mid_rst_grant", 32'(a_grant),     32'd0);
        cur_rst[0] = 1'b0; cur_valid[0] = 4'b1111;
        step();
        chk("rr_restart", 32'(a_grant), 32'd0);

        // Back-pressure
        cur_mode[0] = MODE_FIXED; cur_sel[0] = 2'd0; cur_valid[0] = 4'b0001;
        cur_data[0][0] = 16'h005A;
        step();
        chk("bp_load", 32'(a_out_data), 32'h5A);
        cur_ordy[0] = 1'b0; cur_sel[0] = 2'd1; cur_valid[0] = 4'b0010; cur_data[0][1] = 16'h00C3;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_rdy",  32'(last_rdy[0]), 32'd0);
            chk("bp_hold", 32'(a_out_data),  32'h5A);
        end
        cur_ordy[0] = 1'b1;
        step();
        chk("bp_release_rdy", 32'(last_rdy[0]), 32'h2);
        chk("bp_next_data",   32'(a_out_data),  32'hC3);
        chk("bp_next_valid",  32'(a_out_valid), 32'd1);
        cur_valid[0] = 4'b0000;
        step();
        chk("bp_no_dup", 32'(a_out_valid), 32'd0);

        // Drain to empty
        cur_sel[0] = 2'd2; cur_valid[0] = 4'b0100; cur_data[0][2] = 16'h0077;
        step();
        chk("drain_load_grant", 32'(a_grant), 32'd2);
        cur_valid[0] = 4'b0000;
        step();
        chk("drain_valid", 32'(a_out_valid), 32'd0);
        chk("drain_grant", 32'(a_grant),     32'd2);

        // Instance B directed (non-power-of-two wrap, out-of-range sel)
        rand_en[0] = 1'b1;
        rand_en[1] = 1'b0;
        cur_rst[1] = 1'b1;
        step();
        cur_rst[1] = 1'b0; cur_mode[1] = MODE_RR; cur_ordy[1] = 1'b1;
        cur_valid[1] = 4'b0111;
        cur_data[1][0] = 16'h1111; cur_data[1][1] = 16'h2222; cur_data[1][2] = 16'h3333;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("b_rr_grant", 32'(b_grant), 32'(seq_b[k]));
        end
        chk("b_rr_data", 32'(b_out_data), 32'h1111);
        cur_mode[1] = MODE_FIXED; cur_sel[1] = 2'd3;
        step();
        chk("b_sel3_rdy", 32'(last_rdy[1]), 32'd0);
        step();
        chk("b_sel3_rdy2",  32'(last_rdy[1]), 32'd0);
        chk("b_sel3_valid", 32'(b_out_valid), 32'd0);
        chk("b_sel3_data",  32'(b_out_data),  32'h1111);

        // Random traffic on both instances
        rand_en[1] = 1'b1;
        for (int k = 0; k < 3000; k++) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
